// File: rtl/bin_to_ieee_if.sv
// Request/result bundle for bin_to_ieee: 8.8 fixed-point in, reduced float pair out.
interface bin_to_ieee_if;
   logic       start;
   logic [7:0] decimal_portion;
   logic [7:0] fraction_portion;
   logic [7:0] mantissa;
   logic [7:0] exponent;
   logic       zero;
   logic       busy;
   logic       done;

   modport master (
      output start, decimal_portion, fraction_portion,
      input  mantissa, exponent, zero, busy, done
   );

   modport slave (
      input  start, decimal_portion, fraction_portion,
      output mantissa, exponent, zero, busy, done
   );
endinterface

// File: rtl/bin_to_ieee.sv
// Normalises an unsigned 8.8 value by iterative left shifts into mantissa/exponent (bias 127).
// Optional round-to-nearest-even packing: define BIN_TO_IEEE_ROUND_EN; default truncates.
module bin_to_ieee (
   input  logic         clock_i,
   input  logic         reset_i,
   bin_to_ieee_if.slave bus
);

   // The pack step is taken on the edge that leaves NORM (or on the load edge for a
   // zero input), so done lands after edge k+2 and the block is already back in IDLE.
   typedef enum logic {IDLE, NORM} state_t;

   state_t      state_q, state_d;
   logic [15:0] v_q, v_d;
   logic [3:0]  k_q, k_d;
   logic [7:0]  mantissa_q, mantissa_d;
   logic [7:0]  exponent_q, exponent_d;
   logic        zero_q, zero_d;
   logic        done_q, done_d;

   logic [7:0]  pack_mantissa;
   logic [7:0]  pack_exponent;
   logic [15:0] load_value;

   assign load_value = {bus.decimal_portion, bus.fraction_portion};

`ifdef BIN_TO_IEEE_ROUND_EN
   logic       round_up;
   logic [8:0] mantissa_sum;

   assign round_up      = v_q[6] & ((|v_q[5:0]) | v_q[7]);
   assign mantissa_sum  = {1'b0, v_q[14:7]} + {8'd0, round_up};
   assign pack_mantissa = mantissa_sum[7:0];
   // Carry out of the mantissa bumps the exponent by one.
   assign pack_exponent = mantissa_sum[8] ? (8'd135 - {4'd0, k_q})
                                          : (8'd134 - {4'd0, k_q});
`else
   assign pack_mantissa = v_q[14:7];
   assign pack_exponent = 8'd134 - {4'd0, k_q};
`endif

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         v_q        <= 16'd0;
         k_q        <= 4'd0;
         mantissa_q <= 8'd0;
         exponent_q <= 8'd0;
         zero_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         v_q        <= v_d;
         k_q        <= k_d;
         mantissa_q <= mantissa_d;
         exponent_q <= exponent_d;
         zero_q     <= zero_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      v_d        = v_q;
      k_d        = k_q;
      mantissa_d = mantissa_q;
      exponent_d = exponent_q;
      zero_d     = zero_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               v_d = load_value;
               k_d = 4'd0;
               if (load_value == 16'd0) begin
                  mantissa_d = 8'd0;
                  exponent_d = 8'd0;
                  zero_d     = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (v_q[15]) begin
               mantissa_d = pack_mantissa;
               exponent_d = pack_exponent;
               zero_d     = 1'b0;
               done_d     = 1'b1;
               state_d    = IDLE;
            end else begin
               v_d = {v_q[14:0], 1'b0};
               k_d = k_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mantissa = mantissa_q;
   assign bus.exponent = exponent_q;
   assign bus.zero     = zero_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bin_to_ieee.sv
// Directed bench for bin_to_ieee: results, latency, busy/done timing, reset abort, back-to-back.
module tb_bin_to_ieee;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   cyc;

   bin_to_ieee_if bif ();

   bin_to_ieee dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive a request before an edge; returns after the loading edge (+1) with start low
   // and the inputs scrambled so any late sampling would corrupt the result.
   task automatic launch(input logic [15:0] val);
      @(negedge clk);
      bif.start            = 1'b1;
      bif.decimal_portion  = val[15:8];
      bif.fraction_portion = val[7:0];
      @(posedge clk);
      #1;
      bif.start            = 1'b0;
      bif.decimal_portion  = ~val[15:8];
      bif.fraction_portion = ~val[7:0];
   endtask

   // cyc counts edges from the loading edge (edge 1) until done is seen.
   task automatic wait_done(input string tag);
      cyc = 1;
      while (!bif.done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_done_seen"}, {31'd0, bif.done}, 32'd1);
   endtask

   task automatic convert(input string tag, input logic [15:0] val, input int lat,
                          input logic [7:0] mant, input logic [7:0] expo, input logic z);
      launch(val);
      if (lat > 1) check({tag, "_busy"}, {31'd0, bif.busy}, 32'd1);
      wait_done(tag);
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_mantissa"}, {24'd0, bif.mantissa}, {24'd0, mant});
      check({tag, "_exponent"}, {24'd0, bif.exponent}, {24'd0, expo});
      check({tag, "_zero"}, {31'd0, bif.zero}, {31'd0, z});
      check({tag, "_busy_low"}, {31'd0, bif.busy}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, bif.done}, 32'd0);
      $display("conv %s in=0x%04h lat=%0d mant=0x%02h exp=%0d zero=%0d",
               tag, val, cyc, bif.mantissa, bif.exponent, bif.zero);
   endtask

   initial begin
      errors               = 0;
      checks               = 0;
      rst                  = 1'b1;
      bif.start            = 1'b0;
      bif.decimal_portion  = 8'd0;
      bif.fraction_portion = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mantissa", {24'd0, bif.mantissa}, 32'd0);
      check("rst_exponent", {24'd0, bif.exponent}, 32'd0);
      check("rst_zero", {31'd0, bif.zero}, 32'd0);
      check("rst_busy", {31'd0, bif.busy}, 32'd0);
      check("rst_done", {31'd0, bif.done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      convert("v0330", 16'h0330, 8, 8'h98, 8'd128, 1'b0);
      convert("v0100", 16'h0100, 9, 8'h00, 8'd127, 1'b0);
      convert("v0001", 16'h0001, 17, 8'h00, 8'd119, 1'b0);
      convert("v0000", 16'h0000, 1, 8'h00, 8'd0, 1'b1);
`ifdef BIN_TO_IEEE_ROUND_EN
      convert("vFFFF", 16'hFFFF, 2, 8'h00, 8'd135, 1'b0);
      convert("v80C0", 16'h80C0, 2, 8'h02, 8'd134, 1'b0);
      convert("v8040", 16'h8040, 2, 8'h00, 8'd134, 1'b0);
`else
      convert("vFFFF", 16'hFFFF, 2, 8'hFF, 8'd134, 1'b0);
      convert("v80C0", 16'h80C0, 2, 8'h01, 8'd134, 1'b0);
      convert("v8040", 16'h8040, 2, 8'h00, 8'd134, 1'b0);
`endif
      convert("v0A80", 16'h0A80, 6, 8'h50, 8'd130, 1'b0);

      // start pulsed while busy must be ignored
      launch(16'h0100);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bif.start            = 1'b1;
      bif.decimal_portion  = 8'h00;
      bif.fraction_portion = 8'h01;
      @(negedge clk);
      bif.start = 1'b0;
      cyc = 4;
      while (!bif.done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("ign_latency", cyc, 9);
      check("ign_exponent", {24'd0, bif.exponent}, 32'd127);
      $display("conv ignore_busy lat=%0d mant=0x%02h exp=%0d", cyc, bif.mantissa, bif.exponent);

      // back-to-back: new start accepted in the done cycle
      launch(16'hFFFF);
      wait_done("b2b_a");
      bif.start            = 1'b1;
      bif.decimal_portion  = 8'h03;
      bif.fraction_portion = 8'h30;
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      check("b2b_busy", {31'd0, bif.busy}, 32'd1);
      wait_done("b2b_b");
      check("b2b_latency", cyc, 8);
      check("b2b_mantissa", {24'd0, bif.mantissa}, 32'h98);
      check("b2b_exponent", {24'd0, bif.exponent}, 32'd128);
      $display("conv back_to_back lat=%0d mant=0x%02h exp=%0d", cyc, bif.mantissa, bif.exponent);

      // reset during NORM aborts with no done
      launch(16'h0001);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_mantissa", {24'd0, bif.mantissa}, 32'd0);
      check("abort_exponent", {24'd0, bif.exponent}, 32'd0);
      check("abort_busy", {31'd0, bif.busy}, 32'd0);
      check("abort_done", {31'd0, bif.done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bif.done || bif.busy) cyc++;
      end
      check("abort_quiet", cyc, 0);
      $display("conv reset_abort busy_or_done_cycles=%0d", cyc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
